// File: rtl/me_iddmm_top.sv
// me_iddmm_top: word-serial X^Y mod M engine built on a digit-serial interleaved Montgomery multiplier
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active high (1 = in reset)
//   me_start    one-cycle pulse; (re)arms operand capture and drops any operation in flight
//   me_x        base word, qualified by me_x_valid (LSW first)
//   me_y        exponent word, qualified by me_y_valid (LSW first)
//   me_result   result word, qualified by me_valid (LSW first, N consecutive cycles)
//
// The default constants describe the odd modulus 2^(K*N-1)+1, whose RR (=4) and
// M_PRIME (=2^K-1) are closed-form; real instantiations pass the Paillier modulus
// together with its matching RR and M_PRIME.
module me_iddmm_top #(
    parameter int K = 256,
    parameter int N = 16,
    parameter logic [K*N-1:0] MODULUS = {1'b1, {(K*N-2){1'b0}}, 1'b1},
    parameter logic [K*N-1:0] RR = {{(K*N-3){1'b0}}, 3'd4},
    parameter logic [K-1:0] M_PRIME = {K{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         me_start,
    input  logic [K-1:0] me_x,
    input  logic         me_x_valid,
    input  logic [K-1:0] me_y,
    input  logic         me_y_valid,
    output logic [K-1:0] me_result,
    output logic         me_valid
);
    localparam int KN = K * N;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int BW = $clog2(KN);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [CW-1:0] NW = CW'(N);
    localparam logic [KN-1:0] ONE = {{(KN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, LOAD, PRE, EXP, POST, OUT} state_t;
    typedef enum logic [1:0] {PH_AB, PH_M, PH_RED, PH_FIN} ph_t;
    typedef enum logic [2:0] {OP_XM, OP_R, OP_SQ, OP_MUL, OP_POST} op_t;

    state_t state_q;
    ph_t ph_q;
    op_t op_q, op_d;
    logic [KN-1:0] x_q, y_q, xm_q, a_q, t_q;
    logic [K-1:0] th_q, carry_q, m_q;
    logic tt_q;
    logic [IW-1:0] i_q, j_q;
    logic [CW-1:0] cx_q, cy_q, co_q;
    logic [BW-1:0] bit_q;

    logic [KN-1:0] a_vec, b_vec, res;
    logic [K-1:0] mul_a, mul_b, t_w;
    logic [2*K-1:0] prod, sum;
    logic [K:0] fold;
    logic [KN:0] diff;

    // One K x K multiply per cycle: a_i*b_j while accumulating, t0*M_PRIME for the
    // reduction digit, then m*M_j while reducing. t is N words plus th (t[N]) and tt (t[N+1]).
    always_comb begin
        a_vec = op_q == OP_XM ? x_q : op_q == OP_R ? ONE : a_q;
        b_vec = op_q inside {OP_XM, OP_R} ? RR : op_q == OP_SQ ? a_q : op_q == OP_MUL ? xm_q : ONE;
        t_w = t_q[int'(j_q)*K +: K];
        mul_a = ph_q == PH_AB ? a_vec[int'(i_q)*K +: K] : ph_q == PH_M ? t_q[K-1:0] : m_q;
        mul_b = ph_q == PH_AB ? b_vec[int'(j_q)*K +: K] : ph_q == PH_M ? M_PRIME : MODULUS[int'(j_q)*K +: K];
        prod = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
        sum = prod + {{K{1'b0}}, t_w} + {{K{1'b0}}, carry_q};
        fold = (ph_q == PH_AB ? {1'b0, th_q} : {tt_q, th_q}) + {1'b0, sum[2*K-1:K]};
        // t < 2M, so a single conditional subtraction lands in [0, M)
        diff = {th_q[0], t_q} - {1'b0, MODULUS};
        res = diff[KN] ? t_q : diff[KN-1:0];
        op_d = op_q == OP_XM ? OP_R :
               op_q == OP_R ? OP_SQ :
               (op_q == OP_SQ && y_q[bit_q]) ? OP_MUL :
               (op_q == OP_POST || bit_q == '0) ? OP_POST : OP_SQ;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            ph_q <= PH_AB;
            op_q <= OP_XM;
            x_q <= '0;
            y_q <= '0;
            xm_q <= '0;
            a_q <= '0;
            t_q <= '0;
            th_q <= '0;
            tt_q <= 1'b0;
            carry_q <= '0;
            m_q <= '0;
            i_q <= '0;
            j_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
            co_q <= '0;
            bit_q <= '0;
            me_valid <= 1'b0;
            me_result <= '0;
        end else if (me_start) begin
            // Any start (including mid-operation) restarts capture with a clean multiplier
            state_q <= LOAD;
            cx_q <= '0;
            cy_q <= '0;
            ph_q <= PH_AB;
            op_q <= OP_XM;
            t_q <= '0;
            th_q <= '0;
            tt_q <= 1'b0;
            carry_q <= '0;
            i_q <= '0;
            j_q <= '0;
            me_valid <= 1'b0;
            me_result <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (me_x_valid && cx_q != NW) begin
                        x_q[int'(cx_q)*K +: K] <= me_x;
                        cx_q <= cx_q + CW'(1);
                    end
                    if (me_y_valid && cy_q != NW) begin
                        y_q[int'(cy_q)*K +: K] <= me_y;
                        cy_q <= cy_q + CW'(1);
                    end
                    if (cx_q == NW && cy_q == NW) state_q <= PRE;
                end
                PRE, EXP, POST: begin
                    case (ph_q)
                        PH_AB: begin
                            t_q[int'(j_q)*K +: K] <= sum[K-1:0];
                            carry_q <= sum[2*K-1:K];
                            j_q <= j_q + IW'(1);
                            if (j_q == LAST) begin
                                th_q <= fold[K-1:0];
                                tt_q <= fold[K];
                                j_q <= '0;
                                ph_q <= PH_M;
                            end
                        end
                        PH_M: begin
                            m_q <= prod[K-1:0];
                            carry_q <= '0;
                            ph_q <= PH_RED;
                        end
                        PH_RED: begin
                            // Word 0 becomes zero by construction of m and is shifted out
                            carry_q <= sum[2*K-1:K];
                            j_q <= j_q + IW'(1);
                            if (j_q != '0) t_q[(int'(j_q)-1)*K +: K] <= sum[K-1:0];
                            if (j_q == LAST) begin
                                t_q[KN-K +: K] <= fold[K-1:0];
                                th_q <= {{(K-1){1'b0}}, fold[K]};
                                tt_q <= 1'b0;
                                carry_q <= '0;
                                j_q <= '0;
                                i_q <= i_q + IW'(1);
                                ph_q <= i_q == LAST ? PH_FIN : PH_AB;
                            end
                        end
                        default: begin
                            if (op_q == OP_XM) xm_q <= res;
                            else a_q <= res;
                            t_q <= '0;
                            th_q <= '0;
                            i_q <= '0;
                            ph_q <= PH_AB;
                            op_q <= op_d;
                            co_q <= '0;
                            // Every exponent bit is squared; set bits add a multiply by Xm
                            bit_q <= op_q == OP_R ? BW'(KN - 1) : op_d == OP_SQ ? bit_q - BW'(1) : bit_q;
                            state_q <= op_q == OP_POST ? OUT : op_d == OP_POST ? POST : op_d == OP_R ? PRE : EXP;
                        end
                    endcase
                end
                OUT: begin
                    me_valid <= co_q != NW;
                    me_result <= co_q != NW ? a_q[int'(co_q)*K +: K] : '0;
                    co_q <= co_q != NW ? co_q + CW'(1) : co_q;
                    state_q <= co_q != NW ? OUT : IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_me_iddmm_top.sv
// tb_me_iddmm_top: scoreboard bench for me_iddmm_top on a reduced 32-bit (K=8, N=4) configuration
module tb_me_iddmm_top;
    localparam int K = 8;
    localparam int N = 4;
    localparam logic [31:0] MOD = 32'hF123_4567;

    function automatic logic [31:0] f_rr();
        logic [32:0] r;
        r = 33'd1;
        for (int i = 0; i < 64; i++) begin
            r = r << 1;
            if (r >= {1'b0, MOD}) r = r - {1'b0, MOD};
        end
        return r[31:0];
    endfunction

    function automatic logic [7:0] f_mp();
        logic [7:0] r;
        logic [15:0] q;
        r = 8'd0;
        for (int p = 0; p < 256; p++) begin
            q = 16'(MOD[7:0]) * 16'(p);
            if (q[7:0] == 8'hFF) r = 8'(p);
        end
        return r;
    endfunction

    localparam logic [31:0] RR_C = f_rr();
    localparam logic [7:0] MP_C = f_mp();

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic me_start = 1'b0;
    logic [K-1:0] me_x = '0, me_y = '0;
    logic me_x_valid = 1'b0, me_y_valid = 1'b0;
    logic [K-1:0] me_result;
    logic me_valid;

    int total = 0;
    int bad = 0;
    int run_len = 0;
    logic [K-1:0] sb[$];
    logic [K-1:0] exp_w;
    bit got_any;

    me_iddmm_top #(.K(K), .N(N), .MODULUS(MOD), .RR(RR_C), .M_PRIME(MP_C)) dut (
        .clk(clk), .rst_n(rst_n), .me_start(me_start),
        .me_x(me_x), .me_x_valid(me_x_valid),
        .me_y(me_y), .me_y_valid(me_y_valid),
        .me_result(me_result), .me_valid(me_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gold(input logic [31:0] x, input logic [31:0] y);
        longint unsigned r, b, m;
        m = 64'(MOD);
        b = 64'(x) % m;
        r = 1;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % m;
            if (y[i]) r = (r * b) % m;
        end
        return 32'(r);
    endfunction

    function automatic logic [K-1:0] word(input logic [31:0] v, input int k);
        if (k < N) return v[k*K +: K];
        if (k == N) return '0;
        return K'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [31:0] x, input logic [31:0] y, input bit expect_it,
                           input int extra, input int lag);
        logic [31:0] e;
        me_start = 1'b1;
        tick();
        me_start = 1'b0;
        repeat (10) tick();
        for (int c = 0; c < N + 1 + extra + lag; c++) begin
            me_x_valid = c < N + 1 + extra;
            me_x = word(x, c);
            me_y_valid = c >= lag && c - lag < N + 1 + extra;
            me_y = word(y, c - lag);
            tick();
        end
        me_x_valid = 1'b0;
        me_y_valid = 1'b0;
        if (expect_it) begin
            e = gold(x, y);
            for (int k = 0; k < N; k++) sb.push_back(e[k*K +: K]);
        end
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 6000) begin
            tick();
            c++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL timeout: pending=%0d expected=0", sb.size());
            sb.delete();
        end
        repeat (N + 3) tick();
    endtask

    always @(negedge clk) begin
        if (me_valid) begin
            run_len++;
            got_any = sb.size() != 0;
            total++;
            assert (got_any) else begin
                bad++;
                $error("FAIL unexpected_valid: observed=valid result=%h expected=no pending word", me_result);
            end
            if (got_any) begin
                exp_w = sb.pop_front();
                total++;
                assert (me_result === exp_w) else begin
                    bad++;
                    $error("FAIL result_word: observed=%h expected=%h", me_result, exp_w);
                end
            end
        end else if (run_len != 0) begin
            total++;
            assert (run_len == N) else begin
                bad++;
                $error("FAIL valid_len: observed=%0d expected=%0d", run_len, N);
            end
            total++;
            assert (me_result === '0) else begin
                bad++;
                $error("FAIL result_idle: observed=%h expected=0", me_result);
            end
            run_len = 0;
        end
    end

    initial begin
        repeat (3) tick();
        total++;
        assert (me_valid === 1'b0) else begin
            bad++;
            $error("FAIL reset_valid: observed=%b expected=0", me_valid);
        end
        total++;
        assert (me_result === '0) else begin
            bad++;
            $error("FAIL reset_result: observed=%h expected=0", me_result);
        end
        rst_n = 1'b0;
        tick();
        // valid beats with no start are ignored
        for (int c = 0; c < 6; c++) begin
            me_x_valid = 1'b1;
            me_y_valid = 1'b1;
            me_x = K'($urandom);
            me_y = K'($urandom);
            tick();
        end
        me_x_valid = 1'b0;
        me_y_valid = 1'b0;
        repeat (5) tick();
        send_op(32'h9C3E_17A5, 32'hD00D_F00D, 1'b1, 0, 0);
        wait_done();
        send_op(32'h0000_1234, 32'h0000_0000, 1'b1, 0, 0);
        wait_done();
        send_op(MOD + 32'd5, 32'h0000_0001, 1'b1, 0, 0);
        wait_done();
        send_op(32'h0000_0003, 32'h0000_0002, 1'b1, 0, 0);
        wait_done();
        send_op(32'h0000_0000, 32'h0000_0007, 1'b1, 0, 0);
        wait_done();
        send_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0, 0);
        wait_done();
        // extra non-zero beats past N and a staggered exponent stream
        send_op(32'h7FFF_FFEF, 32'h9FFF_F4F7, 1'b1, 3, 2);
        wait_done();
        send_op($urandom, $urandom, 1'b1, 1, 1);
        wait_done();
        // reset in the middle of exponentiation drops the operation
        send_op(32'h0000_0003, 32'h0000_0002, 1'b0, 0, 0);
        repeat (400) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        total++;
        assert (me_valid === 1'b0) else begin
            bad++;
            $error("FAIL valid_in_reset: observed=%b expected=0", me_valid);
        end
        rst_n = 1'b0;
        repeat (50) tick();
        send_op(32'h0000_0003, 32'h0000_0002, 1'b1, 0, 0);
        wait_done();
        // a new start during exponentiation replaces the old operation
        send_op(32'h0055_AA11, 32'h0123_4567, 1'b0, 0, 0);
        repeat (500) tick();
        send_op(32'h2468_ACE0, 32'h8000_0001, 1'b1, 0, 0);
        wait_done();
        repeat (100) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
